mealy_seq_detector: RTL and testbench

//  Parametrised Mealy serial-pattern detector: flags PATTERN (LEN bits) on a qualified bit stream.

---
 rtl/mealy_det_pkg.sv | 62 ++++++
 rtl/sat_counter.sv | 33 +++
 rtl/mealy_seq_detector.sv | 61 ++++++
 tb/tb_mealy_seq_detector.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mealy_det_pkg.sv
// Shared helpers for the serial pattern detector: state width and the
// elaboration-time next-state table builder (KMP-style fallback).
package mealy_det_pkg;

    localparam int MAX_LEN = 16;
    localparam int ENT_W   = 4;
    localparam int TBL_W   = 2 * MAX_LEN * ENT_W;

    function automatic int clog2(input int n);
        int w;
        for (w = 0; (1 << w) < n; w++) begin
        end
        return (w < 1) ? 1 : w;
    endfunction

    // Bit idx of a 16-bit pattern vector.
    function automatic logic pbit(input logic [15:0] pat, input int idx);
        logic [15:0] sh;
        sh = pat >> idx;
        return sh[0];
    endfunction

    // Longest proper prefix of the pattern that is a suffix of
    // (first k pattern bits followed by b). Never returns len.
    function automatic int nxt_state(input int k, input logic b,
                                     input logic [15:0] pat, input int len);
        int   best;
        int   si;
        logic ok;
        logic sb;
        best = 0;
        for (int j = 1; (j <= k + 1) && (j < len); j++) begin
            ok = 1'b1;
            for (int t = 0; t < j; t++) begin
                si = k + 1 - j + t;
                sb = (si == k) ? b : pbit(pat, len - 1 - si);
                if (sb != pbit(pat, len - 1 - t)) ok = 1'b0;
            end
            if (ok) best = j;
        end
        return best;
    endfunction

    // Packed table, entry {k, b} at bit offset (2k+b)*ENT_W.
    function automatic logic [TBL_W-1:0] build_table(input logic [15:0] pat,
                                                     input int len,
                                                     input bit overlap);
        logic [TBL_W-1:0] tbl;
        logic [ENT_W-1:0] ent;
        tbl = '0;
        for (int k = 0; k < len; k++) begin
            for (int bi = 0; bi < 2; bi++) begin
                ent = ENT_W'(nxt_state(k, 1'(bi), pat, len));
                if (!overlap && (k == len - 1) && (1'(bi) == pbit(pat, 0)))
                    ent = '0;
                tbl = tbl | ({{(TBL_W-ENT_W){1'b0}}, ent} << ((2 * k + bi) * ENT_W));
            end
        end
        return tbl;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones; sat is registered alongside cnt.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt;
        if (clr)
            cnt_d = '0;
        else if (inc && !(&cnt))
            cnt_d = cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cnt <= '0;
            sat <= 1'b0;
        end else begin
            cnt <= cnt_d;
            sat <= &cnt_d;
        end
    end

endmodule

// File: rtl/mealy_seq_detector.sv
// Mealy serial-pattern detector: table-driven match state, combinational
// hit on the final pattern bit, saturating hit counter.
module mealy_seq_detector
    import mealy_det_pkg::*;
#(
    parameter int           LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter bit           OVERLAP = 1'b1,
    parameter int           CNT_W   = 8,
    localparam int          SW      = clog2(LEN)
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in,
    output logic             hit,
    output logic [SW-1:0]    match_len,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             cnt_sat
);

    localparam logic [TBL_W-1:0] NXT_TBL = build_table(16'(PATTERN), LEN, OVERLAP);

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;

    // in is sampled only on edges where in_valid=1; there is no back-pressure,
    // a bit presented with in_valid=1 is always consumed on that edge.
    assign hit = areset_n & ~clr & in_valid
               & (state_q == SW'(LEN - 1)) & (in == PATTERN[0]);

    always_comb begin
        state_d = state_q;
        if (clr)
            state_d = '0;
        else if (in_valid)
            state_d = SW'(NXT_TBL >> {state_q, in, 2'b00});
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n)
            state_q <= '0;
        else
            state_q <= state_d;
    end

    assign match_len = state_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .areset_n (areset_n),
        .clr      (clr),
        .inc      (hit),
        .cnt      (hit_cnt),
        .sat      (cnt_sat)
    );

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Bench for mealy_seq_detector: three instances (overlap, non-overlap,
// 2-bit counter) on shared stimulus, history-based model plus vector table.
module tb_mealy_seq_detector;

    localparam logic [3:0] PAT = 4'b1011;

    logic clk = 1'b0;
    logic areset_n = 1'b0;
    logic clr = 1'b0;
    logic in_valid = 1'b0;
    logic in = 1'b0;

    logic       hit_ov, hit_no, hit_st;
    logic [1:0] ml_ov, ml_no, ml_st;
    logic [7:0] cnt_ov, cnt_no;
    logic [1:0] cnt_st;
    logic       sat_ov, sat_no, sat_st;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mealy_seq_detector #(.LEN(4), .PATTERN(PAT), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
        .clk(clk), .areset_n(areset_n), .clr(clr), .in_valid(in_valid), .in(in),
        .hit(hit_ov), .match_len(ml_ov), .hit_cnt(cnt_ov), .cnt_sat(sat_ov));

    mealy_seq_detector #(.LEN(4), .PATTERN(PAT), .OVERLAP(1'b0), .CNT_W(8)) dut_no (
        .clk(clk), .areset_n(areset_n), .clr(clr), .in_valid(in_valid), .in(in),
        .hit(hit_no), .match_len(ml_no), .hit_cnt(cnt_no), .cnt_sat(sat_no));

    mealy_seq_detector #(.LEN(4), .PATTERN(PAT), .OVERLAP(1'b1), .CNT_W(2)) dut_st (
        .clk(clk), .areset_n(areset_n), .clr(clr), .in_valid(in_valid), .in(in),
        .hit(hit_st), .match_len(ml_st), .hit_cnt(cnt_st), .cnt_sat(sat_st));

    // ---------------- model: bit history since last restart ----------------
    logic [3:0] m_hist[3];
    int         m_nv[3];
    int         m_cnt[3];
    logic       m_sat[3];
    logic       last_hit[3];

    logic [32:0] exp_q[$];

    function automatic bit ov_of(input int i);
        return (i != 1);
    endfunction

    function automatic int max_of(input int i);
        return (i == 2) ? 3 : 255;
    endfunction

    function automatic logic model_hit(input int i, input logic v, input logic b, input logic c);
        return v & ~c & (m_nv[i] >= 3) & ({m_hist[i][2:0], b} == PAT);
    endfunction

    function automatic int model_ml(input logic [3:0] h, input int nv);
        int best;
        logic ok;
        logic [3:0] x;
        logic [3:0] p;
        best = 0;
        for (int j = 1; j <= 3; j++) begin
            if (j <= nv) begin
                ok = 1'b1;
                for (int t = 0; t < j; t++) begin
                    x = h >> (j - 1 - t);
                    p = PAT >> (3 - t);
                    if (x[0] != p[0]) ok = 1'b0;
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_hist[i] = '0; m_nv[i] = 0; m_cnt[i] = 0; m_sat[i] = 1'b0;
        end
    endtask

    function automatic logic act_hit(input int i);
        case (i)
            0: return hit_ov;
            1: return hit_no;
            default: return hit_st;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle; hit checked mid-low-phase, registers checked via scoreboard.
    task automatic step(input logic v, input logic b, input logic c);
        logic [32:0] e;
        int ml[3];
        logic h;
        @(negedge clk);
        in_valid = v; in = b; clr = c;
        #1;
        for (int i = 0; i < 3; i++) begin
            h = model_hit(i, v, b, c);
            last_hit[i] = act_hit(i);
            chk($sformatf("hit[%0d]", i), {31'd0, act_hit(i)}, {31'd0, h});
            if (c) begin
                m_nv[i] = 0; m_cnt[i] = 0; m_sat[i] = 1'b0;
            end else if (v) begin
                m_hist[i] = {m_hist[i][2:0], b};
                m_nv[i] = (h && !ov_of(i)) ? 0 : ((m_nv[i] < 4) ? m_nv[i] + 1 : 4);
                if (h && m_cnt[i] < max_of(i)) m_cnt[i]++;
                m_sat[i] = (m_cnt[i] == max_of(i));
            end
            ml[i] = model_ml(m_hist[i], m_nv[i]);
        end
        exp_q.push_back({m_sat[2], 8'(m_cnt[2]), 2'(ml[2]),
                         m_sat[1], 8'(m_cnt[1]), 2'(ml[1]),
                         m_sat[0], 8'(m_cnt[0]), 2'(ml[0])});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("ml_ov",  {30'd0, ml_ov},  {30'd0, e[1:0]});
        chk("cnt_ov", {24'd0, cnt_ov}, {24'd0, e[9:2]});
        chk("sat_ov", {31'd0, sat_ov}, {31'd0, e[10]});
        chk("ml_no",  {30'd0, ml_no},  {30'd0, e[12:11]});
        chk("cnt_no", {24'd0, cnt_no}, {24'd0, e[20:13]});
        chk("sat_no", {31'd0, sat_no}, {31'd0, e[21]});
        chk("ml_st",  {30'd0, ml_st},  {30'd0, e[23:22]});
        chk("cnt_st", {24'd0, cnt_st}, {24'd0, e[31:24]});
        chk("sat_st", {31'd0, sat_st}, {31'd0, e[32]});
    endtask

    typedef struct {
        logic       v;
        logic       b;
        logic       c;
        logic       hit_ov;
        logic       hit_no;
        logic [1:0] ml_ov;
        logic [1:0] ml_no;
        logic [7:0] cnt_ov;
        logic [7:0] cnt_no;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // overlap / non-overlap on 1,0,1,1,0,1,1
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 8'd0, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 8'd0, 8'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 2'd3, 8'd0, 8'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 2'd0, 8'd1, 8'd1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 8'd1, 8'd1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 2'd1, 8'd1, 8'd1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd1, 8'd2, 8'd1};
        // clr, then 1,1,0, three bubbles, 1,1
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 8'd0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 8'd0, 8'd0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 8'd0, 8'd0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 8'd0, 8'd0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 8'd0, 8'd0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 8'd0, 8'd0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 8'd0, 8'd0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 2'd3, 8'd0, 8'd0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 2'd0, 8'd1, 8'd1};

        // ---------------- reset ----------------
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ml",  {30'd0, ml_ov},  32'd0);
        chk("rst_cnt", {24'd0, cnt_ov}, 32'd0);
        chk("rst_sat", {31'd0, sat_st}, 32'd0);
        chk("rst_hit", {31'd0, hit_ov}, 32'd0);
        @(negedge clk);
        areset_n = 1'b1;

        // ---------------- vector table ----------------
        for (int n = 0; n < 16; n++) begin
            step(vecs[n].v, vecs[n].b, vecs[n].c);
            chk($sformatf("tbl%0d_hit_ov", n), {31'd0, last_hit[0]}, {31'd0, vecs[n].hit_ov});
            chk($sformatf("tbl%0d_hit_no", n), {31'd0, last_hit[1]}, {31'd0, vecs[n].hit_no});
            chk($sformatf("tbl%0d_ml_ov", n),  {30'd0, ml_ov},  {30'd0, vecs[n].ml_ov});
            chk($sformatf("tbl%0d_ml_no", n),  {30'd0, ml_no},  {30'd0, vecs[n].ml_no});
            chk($sformatf("tbl%0d_cnt_ov", n), {24'd0, cnt_ov}, {24'd0, vecs[n].cnt_ov});
            chk($sformatf("tbl%0d_cnt_no", n), {24'd0, cnt_no}, {24'd0, vecs[n].cnt_no});
        end

        // ---------------- saturation: five overlapping hits ----------------
        step(1'b0, 1'b0, 1'b1);
        for (int r = 0; r < 5; r++) begin
            if (r == 0) step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b0);
            if (r == 2) chk("sat_after_3", {31'd0, sat_st}, 32'd1);
        end
        chk("sat_cnt_hold", {30'd0, cnt_st}, 32'd3);
        chk("sat_flag",     {31'd0, sat_st}, 32'd1);
        chk("sat_ov_cnt",   {24'd0, cnt_ov}, 32'd5);

        // ---------------- clr wins over a completing bit ----------------
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("clr_hit", {31'd0, last_hit[0]}, 32'd0);
        chk("clr_ml",  {30'd0, ml_ov},  32'd0);
        chk("clr_cnt", {24'd0, cnt_ov}, 32'd0);

        // ---------------- async reset mid-match ----------------
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in = 1'b1; clr = 1'b0;
        #2 areset_n = 1'b0;
        #1;
        model_reset();
        chk("arst_ml_ov", {30'd0, ml_ov}, 32'd0);
        chk("arst_ml_no", {30'd0, ml_no}, 32'd0);
        chk("arst_hit",   {31'd0, hit_ov}, 32'd0);
        @(negedge clk);
        areset_n = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        chk("arst_first_hit", {31'd0, last_hit[0]}, 32'd0);
        chk("arst_first_ml",  {30'd0, ml_ov}, 32'd1);

        // ---------------- random traffic ----------------
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 40) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
